// File: rtl/menu_selector_if.sv
// Signal bundle between the VGA timing side / game top-level and menu_selector.
// The master side drives timing and buttons; the slave (menu_selector) returns cursor, choice, done and colour.
interface menu_selector_if #(
  parameter int N_ITEMS = 2
);
  localparam int IDXW = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;

  logic            video_on;
  logic [9:0]      hcnt;
  logic [9:0]      vcnt;
  logic            frame_tick;
  logic            btn_up;
  logic            btn_down;
  logic            btn_sel;
  logic            restart;
  logic [IDXW-1:0] cursor;
  logic [IDXW-1:0] choice;
  logic            done;
  logic [3:0]      r;
  logic [3:0]      g;
  logic [3:0]      b;

  modport master (
    output video_on, hcnt, vcnt, frame_tick, btn_up, btn_down, btn_sel, restart,
    input  cursor, choice, done, r, g, b
  );

  modport slave (
    input  video_on, hcnt, vcnt, frame_tick, btn_up, btn_down, btn_sel, restart,
    output cursor, choice, done, r, g, b
  );
endinterface

// File: rtl/menu_selector.sv
// Start-screen menu: N stacked boxes, cursor driven by button edges, confirm flash, then DONE.
// Pixel colour is registered one cycle behind hcnt/vcnt/video_on; done is combinational on the final flash tick.
module menu_selector #(
  parameter int N_ITEMS      = 2,
  parameter int X0           = 200,
  parameter int Y0           = 180,
  parameter int W            = 240,
  parameter int H            = 60,
  parameter int PITCH        = 80,
  parameter int FLASH_FRAMES = 12
) (
  input  logic           clk,
  input  logic           rst,
  menu_selector_if.slave bus
);

  localparam int IDXW = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
  localparam int CNTW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

  localparam logic [1:0] S_BROWSE = 2'd0;
  localparam logic [1:0] S_FLASH  = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(FLASH_FRAMES - 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N_ITEMS - 1);
  localparam logic [10:0]     X_LO     = 11'(X0);
  localparam logic [10:0]     X_HI     = 11'(X0 + W);

  logic [1:0]      state_q, state_d;
  logic [IDXW-1:0] cursor_q, cursor_d;
  logic [IDXW-1:0] choice_q, choice_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            phase_q, phase_d;
  logic            upPrev_q, downPrev_q, selPrev_q;
  logic [3:0]      rgb_q, rgb_d;

  logic            upEdge, downEdge, selEdge;
  logic            lastTick;
  logic            hitAny;
  logic [IDXW-1:0] hitIdx;
  logic            xIn;
  logic [10:0]     hcnt11, vcnt11;

  assign upEdge   = bus.btn_up   & ~upPrev_q;
  assign downEdge = bus.btn_down & ~downPrev_q;
  assign selEdge  = bus.btn_sel  & ~selPrev_q;

  assign lastTick = (state_q == S_FLASH) && bus.frame_tick && (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    choice_d = choice_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    case (state_q)
      S_BROWSE: begin
        // Select takes priority; opposing up/down edges cancel out.
        if (selEdge) begin
          state_d  = S_FLASH;
          choice_d = cursor_q;
          cnt_d    = '0;
          phase_d  = 1'b1;
        end else if (upEdge && !downEdge) begin
          cursor_d = (cursor_q == '0) ? IDX_LAST : cursor_q - IDXW'(1);
        end else if (downEdge && !upEdge) begin
          cursor_d = (cursor_q == IDX_LAST) ? '0 : cursor_q + IDXW'(1);
        end
      end
      S_FLASH: begin
        if (bus.frame_tick) begin
          phase_d = ~phase_q;
          if (lastTick) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
      end
      S_DONE: begin
        if (bus.restart) begin
          state_d  = S_BROWSE;
          cursor_d = '0;
        end
      end
      default: state_d = S_BROWSE;
    endcase
  end

  assign hcnt11 = {1'b0, bus.hcnt};
  assign vcnt11 = {1'b0, bus.vcnt};

  // Box rows are spaced by PITCH >= H, so at most one row can match.
  always_comb begin
    hitAny = 1'b0;
    hitIdx = '0;
    xIn    = (hcnt11 >= X_LO) && (hcnt11 < X_HI);
    for (int i = 0; i < N_ITEMS; i++) begin
      if (xIn && (vcnt11 >= 11'(Y0 + i * PITCH)) && (vcnt11 < 11'(Y0 + i * PITCH + H))) begin
        hitAny = 1'b1;
        hitIdx = IDXW'(i);
      end
    end
  end

  always_comb begin
    rgb_d = 4'h0;
    if (bus.video_on && hitAny) begin
      case (state_q)
        S_BROWSE: rgb_d = (hitIdx == cursor_q) ? 4'hF : 4'h7;
        S_FLASH:  rgb_d = (hitIdx == choice_q) ? (phase_q ? 4'hF : 4'h0) : 4'h7;
        S_DONE:   rgb_d = (hitIdx == choice_q) ? 4'hF : 4'h3;
        default:  rgb_d = 4'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_BROWSE;
      cursor_q   <= '0;
      choice_q   <= '0;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      upPrev_q   <= 1'b0;
      downPrev_q <= 1'b0;
      selPrev_q  <= 1'b0;
      rgb_q      <= 4'h0;
    end else begin
      state_q    <= state_d;
      cursor_q   <= cursor_d;
      choice_q   <= choice_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      upPrev_q   <= bus.btn_up;
      downPrev_q <= bus.btn_down;
      selPrev_q  <= bus.btn_sel;
      rgb_q      <= rgb_d;
    end
  end

  // Gated by rst so a reset landing on the final tick never reports completion.
  assign bus.done   = lastTick & ~rst;
  assign bus.cursor = cursor_q;
  assign bus.choice = choice_q;
  assign bus.r      = rgb_q;
  assign bus.g      = rgb_q;
  assign bus.b      = rgb_q;

endmodule

// File: tb/tb_menu_selector.sv
// Drives a 4-item and a 2-item menu_selector with identical stimulus and checks both
// against a behavioural model every cycle, plus hand-computed literal expectations.
module tb_menu_selector;

  localparam int X0 = 200;
  localparam int Y0 = 180;
  localparam int W = 240;
  localparam int H = 60;
  localparam int PITCH = 80;
  localparam int FLASH_FRAMES = 12;

  typedef enum int {M_BROWSE, M_FLASH, M_DONE} mstate_t;

  logic clk = 1'b0;
  logic rst;
  logic videoOn;
  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic frameTick, btnUp, btnDown, btnSel, restartIn;

  int vectors = 0;
  int misses = 0;

  menu_selector_if #(.N_ITEMS(4)) if4();
  menu_selector_if #(.N_ITEMS(2)) if2();

  assign if4.video_on = videoOn;
  assign if4.hcnt = hcnt;
  assign if4.vcnt = vcnt;
  assign if4.frame_tick = frameTick;
  assign if4.btn_up = btnUp;
  assign if4.btn_down = btnDown;
  assign if4.btn_sel = btnSel;
  assign if4.restart = restartIn;
  assign if2.video_on = videoOn;
  assign if2.hcnt = hcnt;
  assign if2.vcnt = vcnt;
  assign if2.frame_tick = frameTick;
  assign if2.btn_up = btnUp;
  assign if2.btn_down = btnDown;
  assign if2.btn_sel = btnSel;
  assign if2.restart = restartIn;

  menu_selector #(.N_ITEMS(4), .X0(X0), .Y0(Y0), .W(W), .H(H), .PITCH(PITCH),
                  .FLASH_FRAMES(FLASH_FRAMES)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  menu_selector #(.N_ITEMS(2), .X0(X0), .Y0(Y0), .W(W), .H(H), .PITCH(PITCH),
                  .FLASH_FRAMES(FLASH_FRAMES)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  always #5 clk = ~clk;

  // Behavioural model state, one slot per DUT (slot 0 = 4 items, slot 1 = 2 items).
  int nItems[2] = '{4, 2};
  mstate_t mState[2];
  int mCursor[2], mChoice[2], mTicks[2], mRgb[2];
  bit mPrevUp[2], mPrevDown[2], mPrevSel[2];
  bit modelValid = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      misses++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int nCycles);
    repeat (nCycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int actCursor(input int k);
    return (k == 0) ? int'(if4.cursor) : int'(if2.cursor);
  endfunction
  function automatic int actChoice(input int k);
    return (k == 0) ? int'(if4.choice) : int'(if2.choice);
  endfunction
  function automatic int actDone(input int k);
    return (k == 0) ? int'(if4.done) : int'(if2.done);
  endfunction
  function automatic int actR(input int k);
    return (k == 0) ? int'(if4.r) : int'(if2.r);
  endfunction
  function automatic int actG(input int k);
    return (k == 0) ? int'(if4.g) : int'(if2.g);
  endfunction
  function automatic int actB(input int k);
    return (k == 0) ? int'(if4.b) : int'(if2.b);
  endfunction

  // Colour from geometry: row number by division, inside-box test by remainder.
  function automatic int expColour(input int n, input mstate_t st, input int cur, input int cho,
                                   input int ticks, input bit vid, input int h, input int v);
    int row;
    if (!vid) return 0;
    if (h < X0 || h >= X0 + W || v < Y0) return 0;
    row = (v - Y0) / PITCH;
    if (row >= n || ((v - Y0) % PITCH) >= H) return 0;
    case (st)
      M_BROWSE: return (row == cur) ? 15 : 7;
      M_FLASH:  return (row == cho) ? (((ticks % 2) == 0) ? 15 : 0) : 7;
      default:  return (row == cho) ? 15 : 3;
    endcase
  endfunction

  task automatic modelStep(input int k);
    bit upE, downE, selE;
    int n;
    n = nItems[k];
    if (rst) begin
      mState[k] = M_BROWSE;
      mCursor[k] = 0;
      mChoice[k] = 0;
      mTicks[k] = 0;
      mRgb[k] = 0;
      mPrevUp[k] = 1'b0;
      mPrevDown[k] = 1'b0;
      mPrevSel[k] = 1'b0;
      return;
    end
    mRgb[k] = expColour(n, mState[k], mCursor[k], mChoice[k], mTicks[k], videoOn, int'(hcnt), int'(vcnt));
    upE = btnUp && !mPrevUp[k];
    downE = btnDown && !mPrevDown[k];
    selE = btnSel && !mPrevSel[k];
    case (mState[k])
      M_BROWSE: begin
        if (selE) begin
          mState[k] = M_FLASH;
          mChoice[k] = mCursor[k];
          mTicks[k] = 0;
        end else if (upE && !downE) begin
          mCursor[k] = (mCursor[k] + n - 1) % n;
        end else if (downE && !upE) begin
          mCursor[k] = (mCursor[k] + 1) % n;
        end
      end
      M_FLASH: begin
        if (frameTick) begin
          mTicks[k]++;
          if (mTicks[k] == FLASH_FRAMES) mState[k] = M_DONE;
        end
      end
      default: begin
        if (restartIn) begin
          mState[k] = M_BROWSE;
          mCursor[k] = 0;
        end
      end
    endcase
    mPrevUp[k] = btnUp;
    mPrevDown[k] = btnDown;
    mPrevSel[k] = btnSel;
  endtask

  // Model advances on every rising edge with the inputs that were stable before it.
  initial begin
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) modelStep(k);
      modelValid = 1'b1;
    end
  end

  // Every falling edge: registered outputs against the model, done against the current inputs.
  initial begin
    int expDone;
    forever begin
      @(negedge clk);
      if (modelValid) begin
        for (int k = 0; k < 2; k++) begin
          expDone = (!rst && mState[k] == M_FLASH && frameTick && mTicks[k] == FLASH_FRAMES - 1) ? 1 : 0;
          checkOutput($sformatf("model cursor[%0d]", k), actCursor(k), mCursor[k]);
          checkOutput($sformatf("model choice[%0d]", k), actChoice(k), mChoice[k]);
          checkOutput($sformatf("model done[%0d]", k), actDone(k), expDone);
          checkOutput($sformatf("model r[%0d]", k), actR(k), mRgb[k]);
          checkOutput($sformatf("model g[%0d]", k), actG(k), mRgb[k]);
          checkOutput($sformatf("model b[%0d]", k), actB(k), mRgb[k]);
        end
      end
    end
  end

  initial begin
    int bh[9] = '{199, 200, 439, 440, 300, 300, 300, 300, 300};
    int bv[9] = '{200, 200, 200, 200, 239, 240, 259, 260, 200};
    int bvid[9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
    int bexp[9] = '{0, 7, 7, 0, 7, 0, 0, 15, 0};
    int c4[3] = '{1, 2, 3};
    int c2[3] = '{1, 0, 1};

    rst = 1'b1;
    videoOn = 1'b1;
    hcnt = 10'd300;
    vcnt = 10'd200;
    frameTick = 1'b0;
    btnUp = 1'b0;
    btnDown = 1'b0;
    btnSel = 1'b0;
    restartIn = 1'b0;
    applyStimulus(3);
    checkOutput("reset cursor", int'(if4.cursor), 0);
    checkOutput("reset rgb", int'(if4.r), 0);
    checkOutput("reset done", int'(if4.done), 0);

    rst = 1'b0;
    applyStimulus(1);
    checkOutput("box0 cursor0 rgb", int'(if4.r), 15);

    for (int i = 0; i < 3; i++) begin
      btnDown = 1'b1;
      applyStimulus(1);
      checkOutput("down cursor4", int'(if4.cursor), c4[i]);
      checkOutput("down cursor2", int'(if2.cursor), c2[i]);
      btnDown = 1'b0;
      applyStimulus(1);
    end
    checkOutput("box0 cursor1 rgb2", int'(if2.r), 7);

    btnDown = 1'b1;
    applyStimulus(1);
    btnDown = 1'b0;
    applyStimulus(1);
    btnUp = 1'b1;
    applyStimulus(1);
    checkOutput("up wrap cursor4", int'(if4.cursor), 3);
    btnUp = 1'b0;
    applyStimulus(1);
    btnUp = 1'b1;
    btnDown = 1'b1;
    applyStimulus(1);
    checkOutput("up+down cursor4", int'(if4.cursor), 3);
    btnDown = 1'b0;
    btnUp = 1'b0;
    applyStimulus(1);
    btnUp = 1'b1;
    applyStimulus(4);
    checkOutput("held up cursor4", int'(if4.cursor), 2);
    btnUp = 1'b0;
    applyStimulus(1);

    btnSel = 1'b1;
    btnUp = 1'b1;
    frameTick = 1'b1;
    applyStimulus(1);
    checkOutput("sel cursor4", int'(if4.cursor), 2);
    checkOutput("sel choice4", int'(if4.choice), 2);
    checkOutput("sel choice2", int'(if2.choice), 0);
    btnSel = 1'b0;
    btnUp = 1'b0;
    frameTick = 1'b0;
    vcnt = 10'd360;
    applyStimulus(1);
    checkOutput("flash entry rgb4", int'(if4.r), 15);

    for (int i = 1; i <= FLASH_FRAMES; i++) begin
      frameTick = 1'b1;
      btnDown = (i % 2) == 1;
      #1;
      checkOutput("flash done4", int'(if4.done), (i == FLASH_FRAMES) ? 1 : 0);
      applyStimulus(1);
      frameTick = 1'b0;
      applyStimulus(2);
      if (i < FLASH_FRAMES) checkOutput("blink rgb4", int'(if4.r), ((i % 2) == 0) ? 15 : 0);
    end
    btnDown = 1'b0;
    checkOutput("done rgb4 box2", int'(if4.r), 15);
    checkOutput("flash cursor4", int'(if4.cursor), 2);
    vcnt = 10'd200;
    applyStimulus(1);
    checkOutput("done rgb4 box0", int'(if4.r), 3);
    checkOutput("done rgb2 box0", int'(if2.r), 15);

    btnUp = 1'b1;
    applyStimulus(1);
    btnUp = 1'b0;
    applyStimulus(1);
    checkOutput("done cursor4 held", int'(if4.cursor), 2);
    checkOutput("done choice4 held", int'(if4.choice), 2);
    restartIn = 1'b1;
    applyStimulus(1);
    restartIn = 1'b0;
    checkOutput("restart cursor4", int'(if4.cursor), 0);
    applyStimulus(1);
    checkOutput("restart rgb4", int'(if4.r), 15);

    btnDown = 1'b1;
    applyStimulus(1);
    btnDown = 1'b0;
    applyStimulus(1);
    restartIn = 1'b1;
    applyStimulus(1);
    restartIn = 1'b0;
    applyStimulus(1);
    checkOutput("browse restart cursor4", int'(if4.cursor), 1);

    for (int i = 0; i < 9; i++) begin
      hcnt = 10'(bh[i]);
      vcnt = 10'(bv[i]);
      videoOn = bvid[i][0];
      applyStimulus(1);
      checkOutput($sformatf("bound rgb4 (%0d,%0d)", bh[i], bv[i]), int'(if4.r), bexp[i]);
      checkOutput($sformatf("bound rgb2 (%0d,%0d)", bh[i], bv[i]), int'(if2.r), bexp[i]);
    end
    videoOn = 1'b1;
    hcnt = 10'd300;
    vcnt = 10'd200;

    btnSel = 1'b1;
    applyStimulus(1);
    btnSel = 1'b0;
    for (int i = 0; i < FLASH_FRAMES - 1; i++) begin
      frameTick = 1'b1;
      applyStimulus(1);
      frameTick = 1'b0;
      applyStimulus(1);
    end
    rst = 1'b1;
    frameTick = 1'b1;
    #1;
    checkOutput("rst mid-flash done4", int'(if4.done), 0);
    applyStimulus(1);
    checkOutput("rst cursor4", int'(if4.cursor), 0);
    checkOutput("rst choice4", int'(if4.choice), 0);
    checkOutput("rst rgb4", int'(if4.r), 0);
    rst = 1'b0;
    frameTick = 1'b0;
    applyStimulus(3);
    checkOutput("post-rst rgb4", int'(if4.r), 15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
